// File: rtl/traffic_light_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_ctrl_if
// Description : Lamp/status bundle of the two-road traffic-light controller.
//               master : driven by the controller
//               slave  : observed by a monitor or the board top level
//   out   [5:0] lamps {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
//   tick        1 Hz enable, one clock wide
//   phase [1:0] current controller state (debug/verification)
// Revision    : 1.0 - initial release
// ============================================================================
interface traffic_light_ctrl_if;
  logic [5:0] out;
  logic       tick;
  logic [1:0] phase;

  modport master (output out, output tick, output phase);
  modport slave  (input  out, input  tick, input  phase);
endinterface : traffic_light_ctrl_if
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_ctrl
// Description : Two-road (north-south / east-west) traffic-light controller.
//               A prescaler turns the board clock into a one-cycle 1 Hz tick
//               enable, a seconds counter times each phase, and a four-state
//               Moore FSM drives the six lamps. Single clock domain; the
//               tick is a clock enable, never a derived clock.
// Ports       :
//   clk100mhz  in   system clock, rising edge
//   clr        in   asynchronous reset, active low
//   lamps      if   master side of traffic_light_ctrl_if (out, tick, phase)
// Parameters  :
//   CLK_HZ     clock cycles per tick (>= 1)
//   GREEN_SEC  green phase length in ticks (>= 1)
//   YELLOW_SEC yellow phase length in ticks (>= 1)
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl #(
  parameter int CLK_HZ     = 100000000,
  parameter int GREEN_SEC  = 45,
  parameter int YELLOW_SEC = 15
) (
  input  wire logic             clk100mhz,
  input  wire logic             clr,
  traffic_light_ctrl_if.master  lamps
);

  // --------------------------------------------------------------------------
  // Widths: $clog2 of each counter's range, never narrower than one bit.
  // --------------------------------------------------------------------------
  localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SEC_MAX = (GREEN_SEC > YELLOW_SEC) ? GREEN_SEC : YELLOW_SEC;
  localparam int SEC_W   = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;

  localparam logic [PRESC_W-1:0] C_PRESC_LAST  = PRESC_W'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0]   C_GREEN_LAST  = SEC_W'(GREEN_SEC - 1);
  localparam logic [SEC_W-1:0]   C_YELLOW_LAST = SEC_W'(YELLOW_SEC - 1);

  // Lamp patterns {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
  localparam logic [5:0] C_LAMP_NS_GREEN  = 6'b001_100;
  localparam logic [5:0] C_LAMP_NS_YELLOW = 6'b010_100;
  localparam logic [5:0] C_LAMP_EW_GREEN  = 6'b100_001;
  localparam logic [5:0] C_LAMP_EW_YELLOW = 6'b100_010;

  typedef enum logic [1:0] {
    S0 = 2'd0,  // NS green,  EW red
    S1 = 2'd1,  // NS yellow, EW red
    S2 = 2'd2,  // NS red,    EW green
    S3 = 2'd3   // NS red,    EW yellow
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_q,  tick_d;
  logic [SEC_W-1:0]   sec_q,   sec_d;
  state_t             state_q, state_d;
  logic [5:0]         out_q,   out_d;

  logic               presc_wrap_w;
  logic               expire_w;
  logic [SEC_W-1:0]   phase_last_w;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // Prescaler: 0..CLK_HZ-1; the tick register goes high in the cycle
    // after the terminal count, so the first tick lands CLK_HZ cycles
    // after reset release and then every CLK_HZ cycles.
    presc_wrap_w = (presc_q == C_PRESC_LAST);
    presc_d      = presc_wrap_w ? '0 : presc_q + 1'b1;
    tick_d       = presc_wrap_w;

    // Green states share one duration, yellow states the other.
    phase_last_w = ((state_q == S0) || (state_q == S2)) ? C_GREEN_LAST
                                                        : C_YELLOW_LAST;
    expire_w     = tick_q && (sec_q == phase_last_w);

    sec_d = sec_q;
    if (tick_q) begin
      sec_d = expire_w ? '0 : sec_q + 1'b1;
    end

    state_d = state_q;
    if (expire_w) begin
      case (state_q)
        S0:      state_d = S1;
        S1:      state_d = S2;
        S2:      state_d = S3;
        S3:      state_d = S0;
        default: state_d = S0;
      endcase
    end

    // Lamps decoded from the next state so they register on the same edge
    // as the state and never lag it by a cycle.
    case (state_d)
      S0:      out_d = C_LAMP_NS_GREEN;
      S1:      out_d = C_LAMP_NS_YELLOW;
      S2:      out_d = C_LAMP_EW_GREEN;
      S3:      out_d = C_LAMP_EW_YELLOW;
      default: out_d = C_LAMP_NS_GREEN;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers (FSM, counters and all outputs)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk100mhz or negedge clr) begin
    if (!clr) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      sec_q   <= '0;
      state_q <= S0;
      out_q   <= C_LAMP_NS_GREEN;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      sec_q   <= sec_d;
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign lamps.out   = out_q;
  assign lamps.tick  = tick_q;
  assign lamps.phase = state_q;

endmodule : traffic_light_ctrl
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_ctrl
// Description : Self-checking bench for traffic_light_ctrl. Three instances
//               (4/3/2, 10/45/15, 1/1/1) share clock and reset; expected
//               values come from a timeline model: after edge k since
//               release, ticks consumed = k / CLK_HZ and the phase is the
//               position of that count inside one 2*(G+Y) tick cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl;

  localparam int CHZ [3] = '{4, 10, 1};
  localparam int GS  [3] = '{3, 45, 1};
  localparam int YS  [3] = '{2, 15, 1};

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   k = -1;   // rising edges since the last reset release

  always #5 clk = ~clk;

  always @(posedge clk or negedge clr) begin
    if (!clr) k <= -1;
    else      k <= k + 1;
  end

  traffic_light_ctrl_if if_a ();
  traffic_light_ctrl_if if_b ();
  traffic_light_ctrl_if if_c ();

  traffic_light_ctrl #(.CLK_HZ(4),  .GREEN_SEC(3),  .YELLOW_SEC(2))
    dut_a (.clk100mhz(clk), .clr(clr), .lamps(if_a));
  traffic_light_ctrl #(.CLK_HZ(10), .GREEN_SEC(45), .YELLOW_SEC(15))
    dut_b (.clk100mhz(clk), .clr(clr), .lamps(if_b));
  traffic_light_ctrl #(.CLK_HZ(1),  .GREEN_SEC(1),  .YELLOW_SEC(1))
    dut_c (.clk100mhz(clk), .clr(clr), .lamps(if_c));

  logic [5:0] o_v [3];
  logic [1:0] p_v [3];
  logic       t_v [3];
  always_comb begin
    o_v[0] = if_a.out; p_v[0] = if_a.phase; t_v[0] = if_a.tick;
    o_v[1] = if_b.out; p_v[1] = if_b.phase; t_v[1] = if_b.tick;
    o_v[2] = if_c.out; p_v[2] = if_c.phase; t_v[2] = if_c.tick;
  end

  // ---------------- reference model ----------------
  function automatic int exp_phase(int kk, int chz, int g, int y);
    int t;
    if (kk < 0) return 0;
    t = (kk / chz) % (2 * (g + y));
    if (t < g)         return 0;
    if (t < g + y)     return 1;
    if (t < 2 * g + y) return 2;
    return 3;
  endfunction

  function automatic logic exp_tick(int kk, int chz);
    if (kk < 0) return 1'b0;
    return ((kk + 1) % chz) == 0;
  endfunction

  function automatic logic [5:0] lamp_of(int ph);
    case (ph)
      0:       return 6'b001_100;
      1:       return 6'b010_100;
      2:       return 6'b100_001;
      default: return 6'b100_010;
    endcase
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (o_v[d] !== 6'b001_100 || p_v[d] !== 2'd0 || t_v[d] !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_hold dut%0d: out=%b phase=%0d tick=%b, want 001100/0/0",
                   d, o_v[d], p_v[d], t_v[d]);
        end
      end
    end
    #2 clr = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (o_v[d] !== 6'b001_100 || p_v[d] !== 2'd0 || t_v[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_release dut%0d: out=%b phase=%0d tick=%b, want 001100/0/0",
                 d, o_v[d], p_v[d], t_v[d]);
      end
    end
  endtask

  task automatic test_tick_cadence();
    int width;
    width = 0;
    repeat (24) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (t_v[d] !== exp_tick(k, CHZ[d])) begin
          n_bad++;
          $display("FAIL tick dut%0d k=%0d: got %b want %b", d, k, t_v[d], exp_tick(k, CHZ[d]));
        end
      end
      width = if_a.tick ? width + 1 : 0;
      n_cmp++;
      if (width > 1) begin
        n_bad++;
        $display("FAIL tick_width dut0 k=%0d: high %0d cycles, want 1", k, width);
      end
    end
  endtask

  task automatic test_phase_timing();
    repeat (100) begin
      @(negedge clk);
      for (int d = 0; d < 3; d += 2) begin
        n_cmp++;
        if (p_v[d] !== 2'(exp_phase(k, CHZ[d], GS[d], YS[d])) ||
            o_v[d] !== lamp_of(exp_phase(k, CHZ[d], GS[d], YS[d]))) begin
          n_bad++;
          $display("FAIL phase_timing dut%0d k=%0d: phase=%0d out=%b want %0d/%b", d, k,
                   p_v[d], o_v[d], exp_phase(k, CHZ[d], GS[d], YS[d]),
                   lamp_of(exp_phase(k, CHZ[d], GS[d], YS[d])));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int guard;
    int s0_len;
    guard = 0;
    @(negedge clk);
    while (exp_phase(k, 4, 3, 2) != 2 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (guard >= 60 || if_a.phase !== 2'd2) begin
      n_bad++;
      $display("FAIL async_wait_s2: phase=%0d after %0d cycles, want 2", if_a.phase, guard);
    end
    #($urandom_range(1, 3)) clr = 1'b0;
    #1;
    n_cmp++;
    if (if_a.out !== 6'b001_100 || if_a.phase !== 2'd0 || if_a.tick !== 1'b0) begin
      n_bad++;
      $display("FAIL async_immediate: out=%b phase=%0d tick=%b, want 001100/0/0",
               if_a.out, if_a.phase, if_a.tick);
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
    #($urandom_range(1, 3)) clr = 1'b1;
    s0_len = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (if_a.phase === 2'd0 && s0_len == i) s0_len++;
    end
    n_cmp++;
    if (s0_len != 12 || if_a.out !== 6'b010_100) begin
      n_bad++;
      $display("FAIL async_s0_len: S0 lasted %0d cycles then out=%b, want 12 then 010100",
               s0_len, if_a.out);
    end
  endtask

  task automatic test_invariants();
    logic [1:0] prev_p [3];
    logic       prev_t [3];
    int         prev_k;
    int         ep;
    logic       ok;
    prev_k = -2;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (o_v[d][3] & o_v[d][0]) begin
          n_bad++;
          $display("FAIL both_green dut%0d k=%0d: out=%b", d, k, o_v[d]);
        end
        n_cmp++;
        if ($countones(o_v[d][5:3]) != 1 || $countones(o_v[d][2:0]) != 1 ||
            !(o_v[d][5] | o_v[d][2])) begin
          n_bad++;
          $display("FAIL lamp_count dut%0d k=%0d: out=%b, want one lamp per road and one red",
                   d, k, o_v[d]);
        end
        ep = exp_phase(k, CHZ[d], GS[d], YS[d]);
        n_cmp++;
        if (p_v[d] !== 2'(ep) || o_v[d] !== lamp_of(ep) || t_v[d] !== exp_tick(k, CHZ[d])) begin
          n_bad++;
          $display("FAIL model dut%0d k=%0d: phase=%0d out=%b tick=%b want %0d/%b/%b", d, k,
                   p_v[d], o_v[d], t_v[d], ep, lamp_of(ep), exp_tick(k, CHZ[d]));
        end
        if (prev_k >= 0 && k == prev_k + 1) begin
          ok = (p_v[d] === prev_p[d]) || (prev_t[d] && p_v[d] === prev_p[d] + 2'd1);
          n_cmp++;
          if (!ok) begin
            n_bad++;
            $display("FAIL phase_step dut%0d k=%0d: %0d -> %0d with prior tick=%b",
                     d, k, prev_p[d], p_v[d], prev_t[d]);
          end
        end
        prev_p[d] = p_v[d];
        prev_t[d] = t_v[d];
      end
      prev_k = k;
      if ($urandom_range(0, 149) == 0) begin
        #($urandom_range(1, 3)) clr = 1'b0;
        @(negedge clk);
        #($urandom_range(1, 3)) clr = 1'b1;
        prev_k = -2;
      end
    end
  endtask

  task automatic test_defaults();
    int s1_start, s2_start, wrap;
    logic [1:0] prev;
    s1_start = -1; s2_start = -1; wrap = -1;
    prev = 2'd0;
    @(negedge clk);
    #2 clr = 1'b0;
    @(negedge clk);
    #2 clr = 1'b1;
    for (int i = 0; i < 1210; i++) begin
      @(negedge clk);
      if (if_b.phase === 2'd1 && s1_start < 0) s1_start = i;
      if (if_b.phase === 2'd2 && s2_start < 0) s2_start = i;
      if (if_b.phase === 2'd0 && prev === 2'd3 && wrap < 0) wrap = i;
      prev = if_b.phase;
    end
    n_cmp++;
    if (s1_start != 450) begin
      n_bad++;
      $display("FAIL defaults_s0_len: got %0d cycles want 450", s1_start);
    end
    n_cmp++;
    if (s2_start - s1_start != 150 || s1_start < 0) begin
      n_bad++;
      $display("FAIL defaults_s1_len: got %0d cycles want 150", s2_start - s1_start);
    end
    n_cmp++;
    if (wrap != 1200) begin
      n_bad++;
      $display("FAIL defaults_period: got %0d cycles want 1200", wrap);
    end
  endtask

  initial begin
    test_reset();
    test_tick_cadence();
    test_phase_timing();
    test_async_reset();
    test_invariants();
    test_defaults();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_traffic_light_ctrl
`default_nettype wire

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Two-road (north-south / east-west) traffic-light controller for the FPGA board, running directly off the 100 MHz board clock. A prescaler produces a one-cycle 1 Hz tick enable; a seconds timer turns that into phase-length expiries (green = 45 s, yellow = 15 s); a 4-state FSM drives the six lamp outputs. The whole block is one clock domain: there are no derived clocks and only clock-enable ticks.

Parameters:
CLK_HZ, 100000000, system clock cycles per 1 s tick; must be >= 1 and is set small in simulation.
GREEN_SEC, 45, length of each green phase in ticks; must be >= 1.
YELLOW_SEC, 15, length of each yellow phase in ticks; must be >= 1.

Ports:
clk100mhz  input  1  system clock; all logic on the rising edge.
clr  input  1  asynchronous, active-low reset (0 = reset).
out  output  6  lamps {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}; 1 = lit.
tick  output  1  1 Hz enable; high for exactly one clk100mhz cycle per CLK_HZ cycles.
phase  output  2  current FSM state encoding (debug/verification).

Behaviour:
- Reset (clr = 0, asynchronous): prescaler = 0, seconds counter = 0, state = S0, tick = 0.
- Reset values: out = 6'b001_100, phase = 2'd0. Reset asserted mid-operation returns to these values immediately, regardless of clock.
- Prescaler:
  - counts 0..CLK_HZ-1 and wraps to 0.
  - tick is registered and is 1 in the cycle after the counter reaches CLK_HZ-1.
  - First tick occurs CLK_HZ cycles after reset release; tick period is exactly CLK_HZ cycles.
  - CLK_HZ = 1 gives tick = 1 every cycle after reset.
- Seconds counter:
  - advances only in cycles where tick = 1.
  - Phase duration D is GREEN_SEC in S0/S2 and YELLOW_SEC in S1/S3.
  - On a tick with counter = D-1: the counter clears to 0 and the FSM advances in the same edge.
  - Otherwise, on a tick, the counter increments.
- FSM states (phase / out):
  - S0 = 0: NS green, EW red, 6'b001_100.
  - S1 = 1: NS yellow, EW red, 6'b010_100.
  - S2 = 2: NS red, EW green, 6'b100_001.
  - S3 = 3: NS red, EW yellow, 6'b100_010.
- Transitions: S0→S1→S2→S3→S0 only, and only on the expiry tick. No other inputs exist.
- Dwell times: each state lasts exactly D ticks, i.e. D*CLK_HZ clock cycles. Full cycle = 2*(GREEN_SEC+YELLOW_SEC)*CLK_HZ cycles (120 s at defaults).
- Output decode:
  - out and phase are registered/Moore outputs and are glitch-free.
  - Invariant: exactly one lamp lit per road.
  - Both green lamps are never lit together.
  - One road is always red.
- Counter widths: $clog2 of the respective maximum, minimum 1 bit. No overflow is possible, since each counter resets at its terminal value.

Test Plan:
- Reset: clr = 0 for 3 cycles, then 1 → out = 6'b001_100, phase = 0, tick = 0. Run CLK_HZ=4, GREEN_SEC=3, YELLOW_SEC=2 for all remaining scenarios.
- Tick cadence: first tick pulse at cycle 4 after reset release, then every 4 cycles, each exactly 1 cycle wide.
- Phase timing, measured from the first rising edge after reset release:
  - out = 001_100 for cycles 0..11.
  - 010_100 for cycles 12..19.
  - 100_001 for cycles 20..31.
  - 100_010 for cycles 32..39.
  - 001_100 again from cycle 40; repeats with period 40.
- Async reset mid-phase: drop clr during S2 between clock edges → out = 001_100 without waiting for an edge; after release, S0 lasts a full 12 cycles.
- Invariants over 10 full cycles: ns_green & ew_green never 1; each road has exactly one lamp lit; phase increments mod 4 only on tick.
- Defaults sanity with CLK_HZ=10, GREEN_SEC=45, YELLOW_SEC=15: S0 lasts 450 cycles, S1 lasts 150 cycles, full cycle = 1200 cycles.
